// File: rtl/column_drawer_pkg.sv
// Shared screen constants, colour type and FSM encoding for the column renderer.
package column_drawer_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COL_W    = 8;

    typedef logic [COL_W-1:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/column_span_calc.sv
// Clamps the wall height to the screen and centres the wall span vertically.
module column_span_calc #(
    parameter int SCREEN_H = 240,
    parameter int HW       = 8,
    parameter int RW       = 8
) (
    input  logic [HW-1:0] wall_h,
    output logic [RW-1:0] top,
    output logic [RW-1:0] bot
);

    localparam int CW = (HW > RW) ? HW : RW;

    logic [CW-1:0] wh_ext;
    logic [CW-1:0] limit;
    logic [CW-1:0] h_clamped;
    logic [RW-1:0] h;

    assign wh_ext    = CW'(wall_h);
    assign limit     = CW'(SCREEN_H);
    assign h_clamped = (wh_ext >= limit) ? limit : wh_ext;
    assign h         = h_clamped[RW-1:0];

    // Odd leftovers put the extra row below the wall (shift floors).
    assign top = (RW'(SCREEN_H) - h) >> 1;
    assign bot = top + h;

endmodule

// File: rtl/column_drawer.sv
// Renders one framebuffer column (ceiling / wall / floor) per task-start pulse.
// fb_we/fb_ready is a valid/ready pair: a write transfers on a cycle where both are high, and fb_addr/fb_data hold until then.
module column_drawer
    import column_drawer_pkg::*;
#(
    parameter int SCREEN_W = column_drawer_pkg::SCREEN_W,
    parameter int SCREEN_H = column_drawer_pkg::SCREEN_H,
    parameter int COL_W    = column_drawer_pkg::COL_W,
    parameter int ADDR_W   = 17,
    parameter int XW       = 9,
    parameter int HW       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              task_start,
    output logic              task_done,
    output logic              busy,
    input  logic [XW-1:0]     col_x,
    input  logic [HW-1:0]     wall_h,
    input  logic [COL_W-1:0]  wall_color,
    input  logic [COL_W-1:0]  ceil_color,
    input  logic [COL_W-1:0]  floor_color,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [COL_W-1:0]  fb_data,
    output logic              fb_we,
    input  logic              fb_ready,
    output state_t            fsm_state
);

    localparam int RW = $clog2(SCREEN_H + 1);

    state_t state, state_nx;

    logic [XW-1:0]     col_x_q;
    logic [HW-1:0]     wall_h_q;
    logic [COL_W-1:0]  wall_q, ceil_q, floor_q;
    logic [RW-1:0]     top_c, bot_c;
    logic [RW-1:0]     top_q, bot_q, row_q;
    logic [ADDR_W-1:0] addr_q;
    logic              start_ok, fire, last_row, col_bad;

    column_span_calc #(
        .SCREEN_H (SCREEN_H),
        .HW       (HW),
        .RW       (RW)
    ) u_span (
        .wall_h (wall_h_q),
        .top    (top_c),
        .bot    (bot_c)
    );

    assign start_ok = (state == IDLE) && task_start;
    assign fire     = (state == DRAW) && fb_ready;
    assign last_row = (row_q == RW'(SCREEN_H - 1));
    assign col_bad  = (int'(col_x_q) >= SCREEN_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        task_done = 1'b0;
        fb_we     = 1'b0;
        fb_data   = '0;
        unique case (state)
            IDLE: begin
                if (task_start) state_nx = SETUP;
            end
            SETUP: begin
                busy     = 1'b1;
                state_nx = col_bad ? DONE : DRAW;
            end
            DRAW: begin
                busy  = 1'b1;
                fb_we = 1'b1;
                if (row_q < top_q)      fb_data = ceil_q;
                else if (row_q < bot_q) fb_data = wall_q;
                else                    fb_data = floor_q;
                if (fb_ready && last_row) state_nx = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                task_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address steps by the row stride; the last row leaves it on the final pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_x_q  <= '0;
            wall_h_q <= '0;
            wall_q   <= '0;
            ceil_q   <= '0;
            floor_q  <= '0;
            top_q    <= '0;
            bot_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
        end else begin
            if (start_ok) begin
                col_x_q  <= col_x;
                wall_h_q <= wall_h;
                wall_q   <= wall_color;
                ceil_q   <= ceil_color;
                floor_q  <= floor_color;
            end
            if (state == SETUP) begin
                top_q  <= top_c;
                bot_q  <= bot_c;
                row_q  <= '0;
                addr_q <= ADDR_W'(col_x_q);
            end
            if (fire && !last_row) begin
                row_q  <= row_q + RW'(1);
                addr_q <= addr_q + ADDR_W'(SCREEN_W);
            end
        end
    end

    assign fb_addr   = addr_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_column_drawer.sv
// Directed bench for column_drawer: full columns, boundaries, stalls, ignored starts and mid-task reset.
module tb_column_drawer;
    import column_drawer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        task_start = 1'b0;
    logic        task_done;
    logic        busy;
    logic [8:0]  col_x = '0;
    logic [7:0]  wall_h = '0;
    logic [7:0]  wall_color = '0;
    logic [7:0]  ceil_color = '0;
    logic [7:0]  floor_color = '0;
    logic [16:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        fb_ready = 1'b1;
    state_t      fsm_state;

    int total = 0;
    int bad = 0;
    logic [24:0] exp_q[$];

    column_drawer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .task_start  (task_start),
        .task_done   (task_done),
        .busy        (busy),
        .col_x       (col_x),
        .wall_h      (wall_h),
        .wall_color  (wall_color),
        .ceil_color  (ceil_color),
        .floor_color (floor_color),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_we       (fb_we),
        .fb_ready    (fb_ready),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_color(input int r, input int wh,
                                               input logic [7:0] cc, input logic [7:0] wc,
                                               input logic [7:0] fc);
        int h;
        int top;
        h   = (wh > 240) ? 240 : wh;
        top = (240 - h) / 2;
        if (r < top)          return cc;
        else if (r < top + h) return wc;
        else                  return fc;
    endfunction

    task automatic run_column(input string tag, input int x, input int wh,
                              input logic [7:0] cc, input logic [7:0] wc, input logic [7:0] fc,
                              input bit stall, input bit extra_start, input int abort_at,
                              input int n_ceil, input int n_wall, input int n_floor);
        int cycle, writes, stalls, done_cnt, done_cycle, c_n, w_n, f_n;
        logic [7:0] d;
        exp_q.delete();
        if (x < 320)
            for (int r = 0; r < 240; r++)
                exp_q.push_back({17'(x + 320 * r), model_color(r, wh, cc, wc, fc)});
        @(negedge clk);
        col_x = 9'(x); wall_h = 8'(wh);
        ceil_color = cc; wall_color = wc; floor_color = fc;
        task_start = 1'b1;
        @(negedge clk);
        task_start = 1'b0;
        cycle = 1; writes = 0; stalls = 0; done_cnt = 0; done_cycle = -1;
        c_n = 0; w_n = 0; f_n = 0;
        check({tag, "_busy_setup"}, 32'(busy), 32'd1);
        while (cycle < 700) begin
            if (abort_at >= 0 && writes == abort_at && fb_we) begin
                #1 rst_n = 1'b0;
                #1;
                check({tag, "_rst_we"}, 32'(fb_we), 32'd0);
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_addr"}, 32'(fb_addr), 32'd0);
                check({tag, "_rst_data"}, 32'(fb_data), 32'd0);
                check({tag, "_rst_state"}, 32'(fsm_state), 32'(IDLE));
                repeat (3) begin
                    @(negedge clk);
                    check({tag, "_rst_nodone"}, 32'(task_done), 32'd0);
                end
                rst_n = 1'b1;
                exp_q.delete();
                return;
            end
            task_start = 1'b0;
            if (extra_start && cycle == 20) begin
                task_start = 1'b1;
                col_x = 9'd7; wall_h = 8'd3;
                ceil_color = 8'hFF; wall_color = 8'hFF; floor_color = 8'hFF;
            end
            if (task_done) begin
                done_cnt++;
                done_cycle = cycle;
                check({tag, "_busy_done"}, 32'(busy), 32'd1);
            end
            fb_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (fb_we) begin
                check({tag, "_q_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check({tag, "_wr"}, 32'({fb_addr, fb_data}), 32'(exp_q[0]));
                    if (fb_ready) begin
                        d = fb_data;
                        void'(exp_q.pop_front());
                        writes++;
                        if (d == cc)      c_n++;
                        else if (d == wc) w_n++;
                        else if (d == fc) f_n++;
                    end else begin
                        stalls++;
                    end
                end
            end
            @(negedge clk);
            cycle++;
            if (done_cycle >= 0 && cycle > done_cycle + 2) break;
        end
        task_start = 1'b0;
        fb_ready = 1'b1;
        check({tag, "_writes"}, 32'(writes), (x < 320) ? 32'd240 : 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_cycle), (x < 320) ? 32'(242 + stalls) : 32'd2);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_we"}, 32'(fb_we), 32'd0);
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_n_ceil"}, 32'(c_n), 32'(n_ceil));
        check({tag, "_n_wall"}, 32'(w_n), 32'(n_wall));
        check({tag, "_n_floor"}, 32'(f_n), 32'(n_floor));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(task_done), 32'd0);
        check("reset_we", 32'(fb_we), 32'd0);
        check("reset_addr", 32'(fb_addr), 32'd0);
        check("reset_data", 32'(fb_data), 32'd0);
        check("reset_state", 32'(fsm_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        run_column("h100", 5, 100, 8'h11, 8'hE0, 8'h22, 1'b0, 1'b0, -1, 70, 100, 70);
        run_column("h255", 319, 255, 8'h33, 8'h44, 8'h55, 1'b0, 1'b0, -1, 0, 240, 0);
        check("h255_last_addr", 32'(fb_addr), 32'd76799);
        run_column("h0", 10, 0, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, -1, 120, 0, 120);
        run_column("h101", 100, 101, 8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0, -1, 69, 101, 70);
        run_column("stall", 17, 60, 8'h61, 8'h62, 8'h63, 1'b1, 1'b0, -1, 90, 60, 90);
        run_column("oob", 400, 100, 8'h71, 8'h72, 8'h73, 1'b0, 1'b0, -1, 0, 0, 0);
        run_column("dbl", 3, 100, 8'h81, 8'h82, 8'h83, 1'b0, 1'b1, -1, 70, 100, 70);
        run_column("rst", 8, 100, 8'h91, 8'h92, 8'h93, 1'b0, 1'b0, 50, 0, 0, 0);
        @(negedge clk);
        run_column("after", 8, 100, 8'hA1, 8'hA2, 8'hA3, 1'b0, 1'b0, -1, 70, 100, 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
